// File: rtl/alu_sequencer.sv
// Fetch/execute sequencer for the 8-bit ALU_J datapath: fetches instruction words,
// drives the ALU, writes results back and evaluates the program-flow opcodes.
module alu_sequencer #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumOpCodeBits = 5,
  parameter int unsigned ParamBits     = 8,
  parameter int unsigned NumStatusBits = 3,
  parameter int unsigned InstrWidth    = 17
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     run,
  output logic                     imem_req,
  output logic [ParamBits-1:0]     imem_addr,
  input  logic                     imem_ack,
  input  logic [InstrWidth-1:0]    imem_rdata,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [ParamBits-1:0]     pc,
  output logic [NumStatusBits-1:0] flags,
  output logic                     busy,
  output logic                     illegal,
  input  logic [1:0]               dbg_sel,
  output logic [DataWidth-1:0]     dbg_data
);

  localparam int unsigned NumRegs    = 4;
  localparam int unsigned RegSelBits = 2;
  localparam int unsigned ZeroBit    = 2;

  localparam logic [NumOpCodeBits-1:0] OpAdd  = NumOpCodeBits'(5'h01);
  localparam logic [NumOpCodeBits-1:0] OpShr  = NumOpCodeBits'(5'h08);
  localparam logic [NumOpCodeBits-1:0] OpVal  = NumOpCodeBits'(5'h09);
  localparam logic [NumOpCodeBits-1:0] OpGoto = NumOpCodeBits'(5'h10);
  localparam logic [NumOpCodeBits-1:0] OpIfz  = NumOpCodeBits'(5'h11);
  localparam logic [NumOpCodeBits-1:0] OpIfnz = NumOpCodeBits'(5'h12);
  localparam logic [NumOpCodeBits-1:0] OpIfeq = NumOpCodeBits'(5'h13);
  localparam logic [NumOpCodeBits-1:0] OpIfst = NumOpCodeBits'(5'h14);
  localparam logic [NumOpCodeBits-1:0] OpIfgt = NumOpCodeBits'(5'h15);

  typedef struct packed {
    logic [NumOpCodeBits-1:0] opcode;
    logic [RegSelBits-1:0]    rd;
    logic [RegSelBits-1:0]    rs;
    logic [ParamBits-1:0]     param;
  } instr_t;

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_t;

  state_t                   state, state_d;
  instr_t                   ir, ir_d;
  instr_t                   fetched;
  logic [ParamBits-1:0]     pc_d, pc_inc;
  logic [NumStatusBits-1:0] flags_d;
  logic [DataWidth-1:0]     regs   [NumRegs];
  logic [DataWidth-1:0]     regs_d [NumRegs];
  logic                     req_d, busy_d, illegal_d;
  logic [NumOpCodeBits-1:0] opcode_d;
  logic [DataWidth-1:0]     op1_d, op2_d;
  logic [ParamBits-1:0]     param_d;

  function automatic logic is_alu_op(input logic [NumOpCodeBits-1:0] op);
    return (op >= OpAdd) && (op <= OpShr);
  endfunction

  function automatic logic is_reserved(input logic [NumOpCodeBits-1:0] op);
    return ((op > OpVal) && (op < OpGoto)) || (op > OpIfgt);
  endfunction

  assign fetched   = instr_t'(imem_rdata);
  assign pc_inc    = pc + ParamBits'(1);
  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_sel];

  // State register plus all datapath/output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StIdle;
      ir           <= '0;
      pc           <= '0;
      flags        <= '0;
      imem_req     <= 1'b0;
      busy         <= 1'b0;
      illegal      <= 1'b0;
      alu_opcode   <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_param    <= '0;
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else begin
      state        <= state_d;
      ir           <= ir_d;
      pc           <= pc_d;
      flags        <= flags_d;
      imem_req     <= req_d;
      busy         <= busy_d;
      illegal      <= illegal_d;
      alu_opcode   <= opcode_d;
      alu_operand1 <= op1_d;
      alu_operand2 <= op2_d;
      alu_param    <= param_d;
      for (int i = 0; i < NumRegs; i++) regs[i] <= regs_d[i];
    end
  end

  // Next-state and next-output logic; ALU drive is loaded on the ack so it is valid throughout EXEC
  always_comb begin
    state_d   = state;
    ir_d      = ir;
    pc_d      = pc;
    flags_d   = flags;
    regs_d    = regs;
    req_d     = 1'b0;
    illegal_d = 1'b0;
    opcode_d  = '0;
    op1_d     = '0;
    op2_d     = '0;
    param_d   = '0;

    case (state)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          req_d   = 1'b1;
        end
      end

      StFetch: begin
        req_d = 1'b1;
        if (imem_ack) begin
          req_d     = 1'b0;
          ir_d      = fetched;
          state_d   = StExec;
          opcode_d  = is_alu_op(fetched.opcode) ? fetched.opcode : '0;
          op1_d     = regs[fetched.rd];
          op2_d     = regs[fetched.rs];
          param_d   = fetched.param;
          illegal_d = is_reserved(fetched.opcode);
        end
      end

      StExec: begin
        pc_d = pc_inc;
        if (is_alu_op(ir.opcode)) begin
          regs_d[ir.rd] = alu_result;
          flags_d       = alu_status;
        end else begin
          // Branch conditions see the registers and flags as they were entering EXEC
          case (ir.opcode)
            OpVal:   regs_d[ir.rd] = DataWidth'(ir.param);
            OpGoto:  pc_d = ir.param;
            OpIfz:   if (flags[ZeroBit])               pc_d = ir.param;
            OpIfnz:  if (!flags[ZeroBit])              pc_d = ir.param;
            OpIfeq:  if (regs[ir.rd] == regs[ir.rs])   pc_d = ir.param;
            OpIfst:  if (regs[ir.rd] <  regs[ir.rs])   pc_d = ir.param;
            OpIfgt:  if (regs[ir.rd] >  regs[ir.rs])   pc_d = ir.param;
            default: ;
          endcase
        end
        state_d = run ? StFetch : StIdle;
        req_d   = run;
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

endmodule
